// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction-memory interface. A load session begins with
// i_start. The loader then reads a byte stream over a valid/ready handshake:
// first a header byte N (the word count), then N big-endian 16-bit words. The
// words are written to consecutive instruction-memory addresses starting at 0.
// The CPU is held in reset while a session is in progress.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin a load session (sampled only in IDLE or DONE)
//   i_in_data    stream byte
//   i_in_valid   i_in_data is valid
//   o_in_ready   loader accepts i_in_data this cycle
//   o_mem_we     instruction-memory write enable, single-cycle pulse
//   o_mem_addr   write address; holds the last address used
//   o_mem_wdata  write data; holds the last written value
//   o_busy       session in progress (HDR, HI, LO, WRITE)
//   o_cpu_hold   CPU reset hold, identical to o_busy
//   o_done       session finished; sticky until the next accepted start
//   o_err        header rejected; sticky until the next accepted start
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_in_ready;
  logic                r_mem_we;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [7:0]          r_hi;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;

  logic                w_xfer;
  logic                w_hdr_bad;
  logic                w_last;
  logic                w_start_ok;

  // r_in_ready is always equal to "state is HDR/HI/LO", so the handshake only
  // depends on state and never on i_in_valid.
  assign w_xfer     = r_in_ready & i_in_valid;
  assign w_hdr_bad  = (i_in_data == 8'd0) || ({1'b0, i_in_data} > DEPTH);
  assign w_last     = (r_remaining == (ADDR_W+1)'(1));
  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_HDR;
      S_HDR:   if (w_xfer) w_state_next = w_hdr_bad ? S_DONE : S_HI;
      S_HI:    if (w_xfer) w_state_next = S_LO;
      S_LO:    if (w_xfer) w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last ? S_DONE : S_HI;
      S_DONE:  if (i_start) w_state_next = S_HDR;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_hi        <= 8'd0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'd0;
    end else begin
      // Handshake and status flags are registered decodes of the next state.
      r_in_ready <= (w_state_next == S_HDR) || (w_state_next == S_HI) ||
                    (w_state_next == S_LO);
      r_mem_we   <= (w_state_next == S_WRITE);
      r_busy     <= (w_state_next == S_HDR) || (w_state_next == S_HI) ||
                    (w_state_next == S_LO)  || (w_state_next == S_WRITE);

      if (w_start_ok) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end

      case (r_state)
        S_HDR: begin
          if (w_xfer) begin
            if (w_hdr_bad) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_remaining <= i_in_data[ADDR_W:0];
              r_addr      <= '0;
            end
          end
        end
        S_HI: begin
          if (w_xfer) r_hi <= i_in_data;
        end
        S_LO: begin
          // Output registers load here so they are valid during WRITE and
          // keep the last written address/data afterwards.
          if (w_xfer) begin
            r_mem_wdata <= {r_hi, i_in_data};
            r_mem_addr  <= r_addr;
          end
        end
        S_WRITE: begin
          // r_addr may roll over after the final word; it is never used then.
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - (ADDR_W+1)'(1);
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_cpu_hold  = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (ADDR_W=4). Each session's byte stream is
// turned into an expected write list by a plain model (header rule plus
// big-endian byte pairing); observed writes are collected by a monitor.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_busy      (busy),
    .o_cpu_hold  (cpu_hold),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  stream[$];
  logic [19:0] exp_w[$];
  logic [19:0] obs_w[$];
  bit          exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: record every write; the loader must never offer in_ready while writing.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      obs_w.push_back({mem_addr, mem_wdata});
      check("ready_during_write", {31'd0, in_ready}, 32'd0);
    end
  end

  // Reference model: header byte N, then N words taken as big-endian byte pairs.
  task automatic build_expect();
    int n;
    exp_w.delete();
    n = int'(stream[0]);
    exp_err = (n == 0) || (n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < n; i++)
        exp_w.push_back({4'(i), stream[1 + 2*i], stream[2 + 2*i]});
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a byte after 'gap' idle cycles and hold it until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, obs_w.size(), exp_w.size());
    if (obs_w.size() == exp_w.size()) begin
      for (int i = 0; i < exp_w.size(); i++)
        check({tag, "_write"}, {12'd0, obs_w[i]}, {12'd0, exp_w[i]});
    end
  endtask

  // Whole session from the bytes currently in 'stream'.
  task automatic run_stream(input string tag, input int maxgap);
    build_expect();
    obs_w.delete();
    do_start();
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < stream.size(); i++)
      send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    @(negedge clk);
    check_writes(tag);
    check({tag, "_err"},      {31'd0, err},      {31'd0, exp_err});
    check({tag, "_busy_end"}, {31'd0, busy},     32'd0);
    check({tag, "_hold_end"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_rdy_end"},  {31'd0, in_ready}, 32'd0);
    if (exp_w.size() > 0) begin
      check({tag, "_addr_hold"},  {28'd0, mem_addr},  {28'd0, exp_w[exp_w.size()-1][19:16]});
      check({tag, "_wdata_hold"}, {16'd0, mem_wdata}, {16'd0, exp_w[exp_w.size()-1][15:0]});
    end
    $display("session %s N=%0d writes=%0d err=%0b", tag, stream[0], obs_w.size(), err);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",    {31'd0, mem_we},   32'd0);
    check("rst_addr",  {28'd0, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_done",  {31'd0, done},     32'd0);
    check("rst_err",   {31'd0, err},      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);

    // Basic load.
    stream = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    run_stream("basic", 0);

    // Header errors.
    stream = '{8'h00};
    run_stream("hdr_zero", 0);
    stream = '{8'h11};
    run_stream("hdr_big", 0);

    // Backpressure, gaps and a byte presented during WRITE.
    stream = '{8'h01, 8'hAB, 8'hCD};
    build_expect();
    obs_w.delete();
    do_start();
    check("bp_errclr", {31'd0, err}, 32'd0);
    send_byte(8'h01, 3);
    send_byte(8'hAB, 3);
    send_byte(8'hCD, 3);
    @(negedge clk);
    in_data = 8'hEE;
    check("bp_write_we",    {31'd0, mem_we},   32'd1);
    check("bp_write_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("bp_done",       {31'd0, done},     32'd1);
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    check_writes("bp");
    $display("session bp N=1 writes=%0d", obs_w.size());

    // Full depth: words 0x0000..0x000F.
    stream = '{8'h10};
    for (int i = 0; i < DEPTH; i++) begin
      stream.push_back(8'h00);
      stream.push_back(8'(i));
    end
    run_stream("full", 1);

    // Reset in the middle of a session.
    stream = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    obs_w.delete();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready},  32'd0);
    check("mid_rst_we",    {31'd0, mem_we},    32'd0);
    check("mid_rst_addr",  {28'd0, mem_addr},  32'd0);
    check("mid_rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},      32'd0);
    check("mid_rst_hold",  {31'd0, cpu_hold},  32'd0);
    check("mid_rst_done",  {31'd0, done},      32'd0);
    check("mid_rst_err",   {31'd0, err},       32'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_nwrites", obs_w.size(), 32'd1);
    $display("session mid_reset writes_before_abort=%0d", obs_w.size());
    stream = '{8'h01, 8'hBE, 8'hEF};
    run_stream("after_rst", 0);

    // start pulsed while in HI has no effect.
    stream = '{8'h01, 8'h5A, 8'hA5};
    build_expect();
    obs_w.delete();
    do_start();
    send_byte(8'h01, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hi_start_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    check_writes("hi_start");
    check("hi_start_err", {31'd0, err}, 32'd0);
    $display("session hi_start N=1 writes=%0d", obs_w.size());

    // start in DONE after an error clears done/err; start held high across DONE->HDR.
    stream = '{8'h00};
    run_stream("pre_done", 0);
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("done_start_done",  {31'd0, done},     32'd0);
    check("done_start_err",   {31'd0, err},      32'd0);
    check("done_start_ready", {31'd0, in_ready}, 32'd1);
    start = 1'b0;
    obs_w.delete();
    stream = '{8'h01, 8'h0F, 8'hF0};
    build_expect();
    send_byte(8'h01, 0);
    send_byte(8'h0F, 0);
    send_byte(8'hF0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    check_writes("done_start");
    $display("session done_start N=1 writes=%0d", obs_w.size());

    // Randomized sessions, including occasional illegal headers.
    for (int s = 0; s < 8; s++) begin
      n = int'($urandom_range(0, DEPTH + 2));
      stream = '{8'(n)};
      if (n > 0 && n <= DEPTH) begin
        for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
      end
      run_stream($sformatf("rand%0d", s), 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the CPU core reads instruction words from instruction memory, and this block writes them.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the CPU in reset (cpu_hold) while loading, then releases it and flags done.

Parameters:
- ADDR_W, 4: instruction memory address width. Depth = 2**ADDR_W. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; sampled only in IDLE or DONE
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  instruction-memory write enable, single-cycle pulse
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  write data
- busy  out  1  load session in progress (HDR, HI, LO, WRITE)
- cpu_hold  out  1  equals busy; drives the CPU reset hold
- done  out  1  session finished; sticky until next accepted start
- err  out  1  header rejected; sticky until next accepted start

Behaviour:
- reset low (async): state=IDLE. All outputs 0, including mem_addr and mem_wdata. Internal hi-byte and counter registers cleared.
- A byte transfers on a rising edge with in_valid=1 and in_ready=1. in_ready is a registered function of state only, never of in_valid.
- IDLE: in_ready=0. start=1 -> HDR, with done=0 and err=0.
- HDR: in_ready=1. The accepted byte is N, the word count.
  - N==0 or N>2**ADDR_W -> err=1, done=1, go to DONE. No writes occur.
  - Otherwise: remaining=N, addr=0, go to HI.
- HI: in_ready=1. The accepted byte is latched as bits [15:8]; go to LO.
- LO: in_ready=1. The accepted byte forms mem_wdata={hi,byte}; go to WRITE.
- WRITE: in_ready=0, mem_we=1 for exactly one cycle with mem_addr=addr.
  - Next edge: addr+1 and remaining-1.
  - remaining reaching 0 -> DONE with done=1; otherwise go to HI.
- DONE: in_ready=0, busy=0, done=1. start=1 -> HDR, clearing done and err.
- Latency: mem_we is asserted in the cycle immediately after the low byte is accepted. Best-case throughput is 3 cycles per word.
- Output holds when mem_we=0:
  - mem_wdata keeps the last written value.
  - mem_addr keeps the last address used.
- Address never wraps. N=2**ADDR_W writes addresses 0..2**ADDR_W-1, then stops.
- start is ignored in HDR, HI, LO and WRITE.
- start held high across DONE->HDR causes no extra effect.
- in_valid gaps: the state machine waits indefinitely in HDR, HI or LO. No timeout.
- Bytes presented while in_ready=0 are not consumed. The source must hold them until accepted.
- Reset mid-session: immediate abort with no further mem_we. Memory contents already written are left as-is. A later start begins a fresh session from address 0.
- cpu_hold=busy. It rises the cycle after start is accepted and falls the cycle DONE is entered.

Test Plan:
- Basic load: reset, start, stream 0x02,0x12,0x34,0x56,0x78 with in_valid always 1. Expect:
  - exactly 2 mem_we pulses: addr0=0x1234, then addr1=0x5678;
  - then done=1, err=0, busy=0, cpu_hold=0.
- Header errors: N=0x00, then a separate session with N=0x11 (ADDR_W=4). Each gives err=1, done=1, zero mem_we pulses and in_ready=0 afterwards.
- Backpressure and gaps: N=1, with in_valid deasserted for 3 cycles between bytes. Also present a byte during WRITE.
  - Expect the byte not consumed while in_ready=0.
  - Expect a single write of addr0=0xABCD for bytes 0xAB,0xCD.
- Full depth: N=16 with words 0x0000..0x000F. Expect addresses 0..15 in order, no wrap, final mem_addr=15, done=1.
- Reset mid-load: assert reset after the HI byte of word 1 is accepted.
  - Expect all outputs 0 immediately and no mem_we.
  - A following start with N=1, bytes 0xBE,0xEF, writes addr0=0xBEEF.
- start handling:
  - Pulse start while in HI: no effect, and the session completes normally.
  - Pulse start in DONE: done and err clear, state goes to HDR, and a new load of N=1 succeeds.
